// File: rtl/wir_ctrl.sv
// rtl/wir_ctrl.sv - IEEE 1500 WIR, bypass register and WSO select; optional WIR_PARITY_EN adds an odd-parity WIR bit
module wir_ctrl (
    input  logic       WRCK,
    input  logic       resetn,
    input  logic       SelectWIR,
    input  logic       CaptureWR,
    input  logic       ShiftWR,
    input  logic       UpdateWR,
    input  logic       WSI,
    input  logic       WPSE,
    input  logic       wbr_so,
    output logic       wbr_si,
    output logic       WSO,
    output logic       wir_extest,
    output logic       wir_wbr_concat,
    output logic       wir_wpc,
    output logic       wir_wpp_bypass,
    output logic       wse_inputs,
    output logic       wse_outputs,
    output logic       hold_inputs,
    output logic       hold_outputs,
    output logic [3:0] instr,
    output logic       wir_err
);

`ifdef WIR_PARITY_EN
    localparam int              SH_W    = 5;
    localparam logic [SH_W-1:0] SH_CAPT = 5'b00001;
`else
    localparam int              SH_W    = 4;
    localparam logic [SH_W-1:0] SH_CAPT = 4'b0001;
`endif

    localparam logic [3:0] WS_EXTEST  = 4'b0001;
    localparam logic [3:0] WS_INTEST  = 4'b0010;
    localparam logic [3:0] WS_PRELOAD = 4'b0011;
    localparam logic [3:0] WP_EXTEST  = 4'b0100;
    localparam logic [3:0] WP_INTEST  = 4'b0101;
    localparam logic [3:0] WP_BYPASS  = 4'b0110;

    logic [SH_W-1:0] r_wir_sh;
    logic [3:0]      r_wir_up;
    logic            r_wby;

    logic w_ws_extest, w_ws_intest, w_ws_preload;
    logic w_wp_extest, w_wp_intest, w_wp_bypass;
    logic w_update, w_upd_ok, w_wby_sel;

    assign w_ws_extest  = (r_wir_up == WS_EXTEST);
    assign w_ws_intest  = (r_wir_up == WS_INTEST);
    assign w_ws_preload = (r_wir_up == WS_PRELOAD);
    assign w_wp_extest  = (r_wir_up == WP_EXTEST);
    assign w_wp_intest  = (r_wir_up == WP_INTEST);
    assign w_wp_bypass  = (r_wir_up == WP_BYPASS);

    assign w_update = SelectWIR & UpdateWR;

`ifdef WIR_PARITY_EN
    logic r_err;

    // Odd parity over instruction plus parity bit; a bad word leaves the instruction untouched.
    assign w_upd_ok = ^r_wir_sh;

    always_ff @(posedge WRCK or negedge resetn) begin
        if (!resetn)
            r_err <= 1'b0;
        else if (w_update)
            r_err <= ~w_upd_ok;
    end

    assign wir_err = r_err;
`else
    assign w_upd_ok = 1'b1;
    assign wir_err  = 1'b0;
`endif

    always_ff @(posedge WRCK or negedge resetn) begin
        if (!resetn)
            r_wir_sh <= '0;
        else if (SelectWIR && CaptureWR)
            r_wir_sh <= SH_CAPT;
        else if (SelectWIR && ShiftWR)
            r_wir_sh <= {WSI, r_wir_sh[SH_W-1:1]};
    end

    always_ff @(posedge WRCK or negedge resetn) begin
        if (!resetn)
            r_wir_up <= 4'b0000;
        else if (w_update && w_upd_ok)
            r_wir_up <= r_wir_sh[3:0];
    end

    // Every instruction that does not route through the WBR (bypass, illegal codes, WP_*) uses the bypass bit.
    assign w_wby_sel = ~SelectWIR & ~wir_wbr_concat;

    always_ff @(posedge WRCK or negedge resetn) begin
        if (!resetn)
            r_wby <= 1'b0;
        else if (w_wby_sel && CaptureWR)
            r_wby <= 1'b0;
        else if (w_wby_sel && ShiftWR)
            r_wby <= WSI;
    end

    assign wir_extest     = w_ws_extest | w_wp_extest;
    assign wir_wbr_concat = w_ws_extest | w_ws_intest | w_ws_preload;
    assign wir_wpc        = w_wp_extest | w_wp_intest | w_wp_bypass;
    assign wir_wpp_bypass = w_wp_bypass;
    assign hold_outputs   = w_ws_extest | w_wp_extest;
    assign hold_inputs    = w_ws_intest | w_wp_intest;

    assign wse_inputs  = (wir_wbr_concat & ShiftWR & ~SelectWIR)
                       | ((w_wp_extest | w_wp_intest) & WPSE);
    assign wse_outputs = wse_inputs;

    assign wbr_si = WSI;
    assign WSO    = SelectWIR      ? r_wir_sh[0] :
                    wir_wbr_concat ? wbr_so      : r_wby;
    assign instr  = r_wir_up;

endmodule

// File: tb/tb_wir_ctrl.sv
// tb/tb_wir_ctrl.sv - directed self-checking bench for wir_ctrl (build with or without WIR_PARITY_EN)
module tb_wir_ctrl;

    logic       WRCK = 1'b0;
    logic       resetn;
    logic       SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, WPSE, wbr_so;
    logic       wbr_si, WSO;
    logic       wir_extest, wir_wbr_concat, wir_wpc, wir_wpp_bypass;
    logic       wse_inputs, wse_outputs, hold_inputs, hold_outputs;
    logic [3:0] instr;
    logic       wir_err;

    int n_checks = 0;
    int n_fail   = 0;

    wir_ctrl dut (
        .WRCK(WRCK), .resetn(resetn),
        .SelectWIR(SelectWIR), .CaptureWR(CaptureWR), .ShiftWR(ShiftWR), .UpdateWR(UpdateWR),
        .WSI(WSI), .WPSE(WPSE), .wbr_so(wbr_so), .wbr_si(wbr_si), .WSO(WSO),
        .wir_extest(wir_extest), .wir_wbr_concat(wir_wbr_concat), .wir_wpc(wir_wpc),
        .wir_wpp_bypass(wir_wpp_bypass), .wse_inputs(wse_inputs), .wse_outputs(wse_outputs),
        .hold_inputs(hold_inputs), .hold_outputs(hold_outputs), .instr(instr), .wir_err(wir_err)
    );

    always #5 WRCK = ~WRCK;

    // {extest, wbr_concat, wpc, wpp_bypass, hold_inputs, hold_outputs}
    logic [5:0] dec;
    assign dec = {wir_extest, wir_wbr_concat, wir_wpc, wir_wpp_bypass, hold_inputs, hold_outputs};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WRCK);
        #1;
    endtask

    task automatic shift_op(input logic [3:0] op, input logic bad_par);
        SelectWIR = 1'b1;
        ShiftWR   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WSI = op[i];
            tick();
        end
`ifdef WIR_PARITY_EN
        WSI = ~(^op) ^ bad_par;
        tick();
`endif
        ShiftWR = 1'b0;
        WSI     = 1'b0;
    endtask

    task automatic load_instr(input logic [3:0] op, input logic bad_par);
        shift_op(op, bad_par);
        UpdateWR = 1'b1;
        tick();
        UpdateWR  = 1'b0;
        SelectWIR = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        SelectWIR = 1'($urandom_range(0, 1));
        CaptureWR = 1'($urandom_range(0, 1));
        ShiftWR   = 1'($urandom_range(0, 1));
        UpdateWR  = 1'($urandom_range(0, 1));
        WSI       = 1'($urandom_range(0, 1));
        WPSE      = 1'($urandom_range(0, 1));
        wbr_so    = 1'($urandom_range(0, 1));
        repeat (3) tick();
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_dec", 32'(dec), 32'h0);
        check("rst_wse", 32'({wse_inputs, wse_outputs}), 32'h0);
        check("rst_wso", 32'(WSO), 32'h0);
        check("rst_err", 32'(wir_err), 32'h0);
        {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, WPSE, wbr_so} = '0;
        resetn = 1'b1;
        tick();

        load_instr(4'b0001, 1'b0);
        check("extest_instr", 32'(instr), 32'h1);
        check("extest_dec", 32'(dec), 32'b110001);
        wbr_so = 1'b1; #1;
        check("extest_wso_hi", 32'(WSO), 32'h1);
        wbr_so = 1'b0; #1;
        check("extest_wso_lo", 32'(WSO), 32'h0);
        ShiftWR = 1'b1; WSI = 1'b1; #1;
        check("extest_wse", 32'({wse_inputs, wse_outputs}), 32'h3);
        check("wbr_si", 32'(wbr_si), 32'h1);
        ShiftWR = 1'b0; WSI = 1'b0;

        SelectWIR = 1'b1; CaptureWR = 1'b1; ShiftWR = 1'b1; WSI = 1'b1;
        tick();
        CaptureWR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cap_shift_wso%0d", i), 32'(WSO), (i == 0) ? 32'h1 : 32'h0);
            tick();
        end
`ifdef WIR_PARITY_EN
        check("cap_shift_wso4", 32'(WSO), 32'h0);
`else
        check("cap_shift_wso4", 32'(WSO), 32'h1);
`endif
        ShiftWR = 1'b0; SelectWIR = 1'b0; WSI = 1'b0;
        check("noupd_instr", 32'(instr), 32'h1);

        // Two stale bits shifted first must fall off the end.
        SelectWIR = 1'b1; ShiftWR = 1'b1; WSI = 1'b1;
        repeat (2) tick();
        load_instr(4'b0101, 1'b0);
        check("wpint_instr", 32'(instr), 32'h5);
        check("wpint_dec", 32'(dec), 32'b001010);
        WPSE = 1'b1; #1;
        check("wpint_wse_on", 32'({wse_inputs, wse_outputs}), 32'h3);
        WPSE = 1'b0; ShiftWR = 1'b1; #1;
        check("wpint_wse_shift", 32'({wse_inputs, wse_outputs}), 32'h0);
        ShiftWR = 1'b0; CaptureWR = 1'b1;
        tick();
        CaptureWR = 1'b0;
        check("wpint_wby_cap", 32'(WSO), 32'h0);
        ShiftWR = 1'b1; WSI = 1'b1;
        tick();
        ShiftWR = 1'b0; WSI = 1'b0;
        check("wpint_wby_shift", 32'(WSO), 32'h1);

        shift_op(4'b0011, 1'b0);
        SelectWIR = 1'b1; UpdateWR = 1'b1; ShiftWR = 1'b1; WSI = 1'b0;
        tick();
        UpdateWR = 1'b0; ShiftWR = 1'b0;
        check("updshift_instr", 32'(instr), 32'h3);
        check("updshift_dec", 32'(dec), 32'b010000);
        check("updshift_wso", 32'(WSO), 32'h1);
        SelectWIR = 1'b0;

        load_instr(4'b1111, 1'b0);
        check("illegal_instr", 32'(instr), 32'hF);
        check("illegal_dec", 32'(dec), 32'h0);
        CaptureWR = 1'b1;
        tick();
        CaptureWR = 1'b0;
        check("illegal_wby_cap", 32'(WSO), 32'h0);
        ShiftWR = 1'b1; WSI = 1'b1;
        tick();
        check("illegal_wby_1", 32'(WSO), 32'h1);
        WSI = 1'b0;
        tick();
        check("illegal_wby_0", 32'(WSO), 32'h0);
        ShiftWR = 1'b0;

        SelectWIR = 1'b1; ShiftWR = 1'b1; WSI = 1'b1;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_instr", 32'(instr), 32'h0);
        check("async_rst_wso", 32'(WSO), 32'h0);
        {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, WPSE, wbr_so} = '0;
        tick();
        resetn = 1'b1;
        tick();

`ifdef WIR_PARITY_EN
        load_instr(4'b0010, 1'b1);
        check("par_bad_instr", 32'(instr), 32'h0);
        check("par_bad_err", 32'(wir_err), 32'h1);
        load_instr(4'b0010, 1'b0);
        check("par_ok_instr", 32'(instr), 32'h2);
        check("par_ok_err", 32'(wir_err), 32'h0);
`else
        load_instr(4'b0010, 1'b0);
        check("intest_instr", 32'(instr), 32'h2);
        check("intest_dec", 32'(dec), 32'b010010);
        check("noparity_err", 32'(wir_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
